// File: rtl/prbs_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// prbs_ctrl_pkg
// Shared definitions for the PRBS31 test controller: controller state
// encoding, PRBS/block geometry constants and the default parameter values
// used by prbs31_test_ctrl and prbs_err_counter.
// ---------------------------------------------------------------------------
package prbs_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SYNC,
    ST_ACQ,
    ST_CHECK,
    ST_DONE
  } ctrlState_e;

  localparam int PRBS_LEN = 31;
  localparam logic [PRBS_LEN-1:0] SEED_VAL = 31'd1;
  localparam int BLOCK_LEN = 32;

  localparam int DEF_WIN_W       = 16;
  localparam int DEF_ERR_W       = 16;
  localparam int DEF_LOCK_CNT    = 32;
  localparam int DEF_LOS_THRESH  = 8;
  localparam int DEF_ACQ_TIMEOUT = 1024;

endpackage

// File: rtl/prbs_err_counter.sv
// ---------------------------------------------------------------------------
// prbs_err_counter
// Saturating error accumulator plus per-block error counter used for
// loss-of-lock detection while the controller is checking.
// Ports:
//   clk_i      clock
//   rst_n_i    synchronous reset, active-high
//   clr_i      clears all counters (run start)
//   en_i       one checked bit this cycle
//   err_in_i   mismatch flag for the checked bit
//   err_cnt_o  accumulated error count, saturates at all-ones
//   err_sat_o  high when err_cnt_o is all-ones
//   los_o      this checked bit brings the block error count to LOS_THRESH
// ---------------------------------------------------------------------------
module prbs_err_counter
  import prbs_ctrl_pkg::*;
#(
  parameter int ERR_W      = DEF_ERR_W,
  parameter int LOS_THRESH = DEF_LOS_THRESH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             err_in_i,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             err_sat_o,
  output logic             los_o
);

  localparam int BPOS_W = $clog2(BLOCK_LEN);
  localparam int BERR_W = $clog2(BLOCK_LEN + 1);

  logic [ERR_W-1:0]  errCnt_q, errCnt_d;
  logic              errSat_q;
  logic [BPOS_W-1:0] blkPos_q;
  logic [BERR_W-1:0] blkErr_q;

  // Loss of lock is judged on the running block count including the
  // current bit, so the bit that crosses the threshold is itself counted.
  assign los_o = en_i && err_in_i && ((int'(blkErr_q) + 1) == LOS_THRESH);

  // Saturating increment of the accumulated error count.
  always_comb begin
    errCnt_d = errCnt_q;
    if (en_i && err_in_i && !errSat_q) begin
      errCnt_d = errCnt_q + 1'b1;
    end
  end

  // The block restarts every BLOCK_LEN checked bits, and also on loss of
  // lock so that a relocked run starts with a fresh block.
  always_ff @(posedge clk_i) begin
    if (rst_n_i || clr_i) begin
      errCnt_q <= '0;
      errSat_q <= 1'b0;
      blkPos_q <= '0;
      blkErr_q <= '0;
    end else if (en_i) begin
      errCnt_q <= errCnt_d;
      errSat_q <= &errCnt_d;
      if (los_o || (blkPos_q == BPOS_W'(BLOCK_LEN - 1))) begin
        blkPos_q <= '0;
        blkErr_q <= '0;
      end else begin
        blkPos_q <= blkPos_q + 1'b1;
        blkErr_q <= blkErr_q + BERR_W'(err_in_i);
      end
    end
  end

  assign err_cnt_o = errCnt_q;
  assign err_sat_o = errSat_q;

endmodule

// File: rtl/prbs31_test_ctrl.sv
// ---------------------------------------------------------------------------
// prbs31_test_ctrl
// Sequencing controller for a PRBS31 generator/checker pair: seeds the
// generator, self-synchronises the checker, acquires lock, counts errors
// over a programmable window and re-acquires on loss of lock.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-high reset
//   start_i, abort_i    run start (IDLE only) / return to IDLE
//   win_len_i           checked bits per run, latched at start
//   err_in_i            checker mismatch for the current bit
//   gen_load_o          load generator seed
//   chk_load_o          checker self-sync (shift received bits in)
//   gen_en_o            advance generator and checker
//   busy_o, locked_o    not IDLE / in CHECK
//   done_o              one-cycle window-complete pulse
//   timeout_o           sticky acquisition timeout
//   err_cnt_o, err_sat_o  saturating error count and its saturation flag
// Optional feature macro PRBS_CTRL_ERR_INJECT_EN adds inject_i / gen_flip_o:
//   an inject pulse in CHECK flips exactly one generated bit.
// ---------------------------------------------------------------------------
module prbs31_test_ctrl
  import prbs_ctrl_pkg::*;
#(
  parameter int WIN_W       = DEF_WIN_W,
  parameter int ERR_W       = DEF_ERR_W,
  parameter int LOCK_CNT    = DEF_LOCK_CNT,
  parameter int LOS_THRESH  = DEF_LOS_THRESH,
  parameter int ACQ_TIMEOUT = DEF_ACQ_TIMEOUT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             err_in_i,
`ifdef PRBS_CTRL_ERR_INJECT_EN
  input  logic             inject_i,
  output logic             gen_flip_o,
`endif
  output logic             gen_load_o,
  output logic             chk_load_o,
  output logic             gen_en_o,
  output logic             busy_o,
  output logic             locked_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic             err_sat_o
);

  localparam int SYNC_W = $clog2(PRBS_LEN);
  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int ACQ_W  = $clog2(ACQ_TIMEOUT + 1);

  ctrlState_e        state_q, state_d;
  logic [WIN_W-1:0]  winCnt_q, winCnt_d, winLen_q;
  logic [SYNC_W-1:0] syncCnt_q, syncCnt_d;
  logic [RUN_W-1:0]  runCnt_q, runCnt_d;
  logic [ACQ_W-1:0]  acqCnt_q, acqCnt_d;
  logic              startAcc, countBit, toHit, doneHit, los, genEn_d;
  logic              genLoad_q, chkLoad_q, genEn_q, busy_q, locked_q, done_q, timeout_q;

  assign startAcc = (state_q == ST_IDLE) && start_i && !abort_i;
  assign genEn_d  = (state_d == ST_SYNC) || (state_d == ST_ACQ) || (state_d == ST_CHECK);

  // Next-state logic. The phase counters are zero outside their own state,
  // so every entry into SYNC or ACQ starts counting afresh. A window that is
  // already complete on entry to CHECK (win_len of 0) goes straight to DONE
  // without consuming a bit; otherwise completion beats loss of lock.
  always_comb begin
    state_d   = state_q;
    winCnt_d  = winCnt_q;
    syncCnt_d = '0;
    runCnt_d  = '0;
    acqCnt_d  = '0;
    countBit  = 1'b0;
    toHit     = 1'b0;
    doneHit   = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SEED;
      ST_SEED:  state_d = ST_SYNC;
      ST_SYNC: begin
        if (syncCnt_q == SYNC_W'(PRBS_LEN - 1)) state_d = ST_ACQ;
        else syncCnt_d = syncCnt_q + 1'b1;
      end
      ST_ACQ: begin
        runCnt_d = err_in_i ? '0 : runCnt_q + 1'b1;
        acqCnt_d = acqCnt_q + 1'b1;
        if (runCnt_d == RUN_W'(LOCK_CNT)) begin
          state_d = ST_CHECK;
        end else if (acqCnt_d == ACQ_W'(ACQ_TIMEOUT)) begin
          state_d = ST_DONE;
          toHit   = 1'b1;
        end
      end
      ST_CHECK: begin
        if (winCnt_q == winLen_q) begin
          state_d = ST_DONE;
          doneHit = 1'b1;
        end else begin
          countBit = 1'b1;
          winCnt_d = winCnt_q + 1'b1;
          if (winCnt_d == winLen_q) begin
            state_d = ST_DONE;
            doneHit = 1'b1;
          end else if (los) begin
            state_d = ST_SYNC;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_i) begin
      state_d   = ST_IDLE;
      winCnt_d  = winCnt_q;
      syncCnt_d = '0;
      runCnt_d  = '0;
      acqCnt_d  = '0;
      countBit  = 1'b0;
      toHit     = 1'b0;
      doneHit   = 1'b0;
    end
  end

  // State and counter registers. The window counter survives loss of lock
  // and is only cleared by an accepted start, which also latches win_len.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      state_q   <= ST_IDLE;
      winCnt_q  <= '0;
      winLen_q  <= '0;
      syncCnt_q <= '0;
      runCnt_q  <= '0;
      acqCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      syncCnt_q <= syncCnt_d;
      runCnt_q  <= runCnt_d;
      acqCnt_q  <= acqCnt_d;
      if (startAcc) begin
        winCnt_q <= '0;
        winLen_q <= win_len_i;
      end else begin
        winCnt_q <= winCnt_d;
      end
    end
  end

  // Strobe outputs are registered from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (rst_n_i) begin
      genLoad_q <= 1'b0;
      chkLoad_q <= 1'b0;
      genEn_q   <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      genLoad_q <= (state_d == ST_SEED);
      chkLoad_q <= (state_d == ST_SEED) || (state_d == ST_SYNC);
      genEn_q   <= genEn_d;
      busy_q    <= (state_d != ST_IDLE);
      locked_q  <= (state_d == ST_CHECK);
      done_q    <= doneHit;
      if (startAcc) timeout_q <= 1'b0;
      else if (toHit) timeout_q <= 1'b1;
    end
  end

  prbs_err_counter #(
    .ERR_W      (ERR_W),
    .LOS_THRESH (LOS_THRESH)
  ) u_err_counter (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (startAcc),
    .en_i      (countBit),
    .err_in_i  (err_in_i),
    .err_cnt_o (err_cnt_o),
    .err_sat_o (err_sat_o),
    .los_o     (los)
  );

`ifdef PRBS_CTRL_ERR_INJECT_EN
  logic flipPend_q, genFlip_q, flipReq;

  assign flipReq = flipPend_q || (inject_i && (state_q == ST_CHECK));

  // A flip request waits until the next cycle that advances the generator,
  // then fires for exactly that one cycle; repeat pulses meanwhile merge.
  always_ff @(posedge clk_i) begin
    if (rst_n_i || (state_d == ST_IDLE)) begin
      flipPend_q <= 1'b0;
      genFlip_q  <= 1'b0;
    end else begin
      genFlip_q  <= flipReq && genEn_d;
      flipPend_q <= flipReq && !genEn_d;
    end
  end

  assign gen_flip_o = genFlip_q;
`endif

  assign gen_load_o = genLoad_q;
  assign chk_load_o = chkLoad_q;
  assign gen_en_o   = genEn_q;
  assign busy_o     = busy_q;
  assign locked_o   = locked_q;
  assign done_o     = done_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_prbs31_test_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prbs31_test_ctrl
// Self-checking bench for prbs31_test_ctrl. Each run drives err_in from a
// per-cycle error table; a run-level model walks the same table to predict
// the done cycle, locked cycles, relock count and final error count. A
// second instance with a 4-bit error counter shares the stimulus to check
// saturation.
// ---------------------------------------------------------------------------
module tb_prbs31_test_ctrl;

  localparam int WIN_W     = 16;
  localparam int SEQ_LEN   = 4096;
  localparam int BUDGET    = 20000;
  localparam int LOCK_N    = 32;
  localparam int LOS_N     = 8;
  localparam int ACQ_TO    = 1024;
  localparam int SYNC_BITS = 31;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic             err_in = 1'b0;

  logic        genLoad, chkLoad, genEn, busy, locked, done, timeout, errSat16;
  logic [15:0] errCnt16;
  logic        sGenLoad, sChkLoad, sGenEn, sBusy, sLocked, sDone, sTimeout, errSat4;
  logic [3:0]  errCnt4;

  int passCount = 0;
  int checkCount = 0;

  bit errSeq [SEQ_LEN];

  int expDone, expEnd, expTimeout, expErr, expLocked, expLos, expSync;

  always #5 clk = ~clk;

  prbs31_test_ctrl dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .win_len_i  (win_len),
    .err_in_i   (err_in),
`ifdef PRBS_CTRL_ERR_INJECT_EN
    .inject_i   (1'b0),
    .gen_flip_o (),
`endif
    .gen_load_o (genLoad),
    .chk_load_o (chkLoad),
    .gen_en_o   (genEn),
    .busy_o     (busy),
    .locked_o   (locked),
    .done_o     (done),
    .timeout_o  (timeout),
    .err_cnt_o  (errCnt16),
    .err_sat_o  (errSat16)
  );

  prbs31_test_ctrl #(.ERR_W(4)) dutSat (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .abort_i    (abort),
    .win_len_i  (win_len),
    .err_in_i   (err_in),
`ifdef PRBS_CTRL_ERR_INJECT_EN
    .inject_i   (1'b0),
    .gen_flip_o (),
`endif
    .gen_load_o (sGenLoad),
    .chk_load_o (sChkLoad),
    .gen_en_o   (sGenEn),
    .busy_o     (sBusy),
    .locked_o   (sLocked),
    .done_o     (sDone),
    .timeout_o  (sTimeout),
    .err_cnt_o  (errCnt4),
    .err_sat_o  (errSat4)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, want %0d", tag, actual, expected);
  endtask

  function automatic bit errAt(input int c);
    if (c >= 0 && c < SEQ_LEN) return errSeq[c];
    return 1'b0;
  endfunction

  task automatic clearSeq();
    for (int i = 0; i < SEQ_LEN; i++) errSeq[i] = 1'b0;
  endtask

  // Run-level prediction from the error table: cycle 0 carries start,
  // cycle 1 is the seed, cycles 2..32 sync, then acquisition and checking.
  task automatic modelRun(input int winLen, input int abortAt);
    int pos, run, acq, win, blk, bpos;
    bit e, fin;
    expDone = -1; expEnd = -1; expTimeout = 0; expErr = 0;
    expLocked = 0; expLos = 0; expSync = 1 + SYNC_BITS;
    pos = 1 + 1 + SYNC_BITS;
    win = 0;
    fin = 1'b0;
    while (!fin) begin
      run = 0;
      acq = 0;
      while (run < LOCK_N && !fin) begin
        if (pos == abortAt) begin
          expEnd = pos + 1;
          fin = 1'b1;
        end else begin
          e = errAt(pos);
          pos++;
          acq++;
          run = e ? 0 : run + 1;
          if (run < LOCK_N && acq == ACQ_TO) begin
            expTimeout = 1;
            expEnd = pos + 1;
            fin = 1'b1;
          end
        end
      end
      blk = 0;
      bpos = 0;
      while (!fin) begin
        expLocked++;
        if (pos == abortAt) begin
          expEnd = pos + 1;
          fin = 1'b1;
        end else if (win == winLen) begin
          expDone = pos + 1;
          expEnd = pos + 2;
          fin = 1'b1;
        end else begin
          e = errAt(pos);
          pos++;
          win++;
          bpos++;
          if (e) begin
            expErr++;
            blk++;
          end
          if (win == winLen) begin
            expDone = pos;
            expEnd = pos + 1;
            fin = 1'b1;
          end else if (e && blk == LOS_N) begin
            expLos++;
            expSync += SYNC_BITS;
            pos += SYNC_BITS;
            break;
          end else if (bpos == 32) begin
            bpos = 0;
            blk = 0;
          end
        end
      end
    end
  endtask

  // One full run: start at cycle 0, optional abort and ignored extra start,
  // observe every cycle at the falling edge until the block is idle again.
  task automatic applyStimulus(input string name, input int winLen,
                               input int abortAt, input int extraStartAt);
    int c, doneCyc, doneCnt, lockedCyc, losCnt, syncCyc, loadCyc, firstEn, endCyc;
    int sat16, sat4;
    bit prevLocked;
    modelRun(winLen, abortAt);
    @(posedge clk); #1;
    win_len = WIN_W'(winLen);
    start = 1'b1;
    abort = 1'b0;
    err_in = errAt(0);
    c = 0;
    doneCyc = -1; doneCnt = 0; lockedCyc = 0; losCnt = 0;
    syncCyc = 0; loadCyc = 0; firstEn = -1; endCyc = -1;
    prevLocked = 1'b0;
    while (endCyc < 0 && c < BUDGET) begin
      @(negedge clk);
      if (c > 0 && !busy) endCyc = c;
      if (done) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = c;
      end
      if (locked) lockedCyc++;
      if (prevLocked && !locked && chkLoad) losCnt++;
      prevLocked = locked;
      if (chkLoad) syncCyc++;
      if (genLoad) loadCyc++;
      if (genEn && firstEn < 0) firstEn = c;
      @(posedge clk); #1;
      c++;
      start = (c == extraStartAt);
      abort = (c == abortAt);
      err_in = errAt(c);
    end
    start = 1'b0;
    abort = 1'b0;
    err_in = 1'b0;
    sat16 = (expErr > 65535) ? 65535 : expErr;
    sat4  = (expErr > 15) ? 15 : expErr;
    checkOutput({name, ".end"}, endCyc, expEnd);
    checkOutput({name, ".doneCycle"}, doneCyc, expDone);
    checkOutput({name, ".doneCount"}, doneCnt, (expDone >= 0) ? 1 : 0);
    checkOutput({name, ".lockedCycles"}, lockedCyc, expLocked);
    checkOutput({name, ".relocks"}, losCnt, expLos);
    checkOutput({name, ".chkLoadCycles"}, syncCyc, expSync);
    checkOutput({name, ".genLoadCycles"}, loadCyc, 1);
    checkOutput({name, ".firstGenEn"}, firstEn, 2);
    checkOutput({name, ".timeout"}, int'(timeout), expTimeout);
    checkOutput({name, ".errCnt"}, int'(errCnt16), sat16);
    checkOutput({name, ".errSat"}, int'(errSat16), (sat16 == 65535) ? 1 : 0);
    checkOutput({name, ".errCnt4"}, int'(errCnt4), sat4);
    checkOutput({name, ".errSat4"}, int'(errSat4), (sat4 == 15) ? 1 : 0);
  endtask

  initial begin
    int pTab [4];
    pTab = '{0, 3, 10, 30};

    $display("[TB] reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.genEn", int'(genEn), 0);
    checkOutput("reset.genLoad", int'(genLoad), 0);
    checkOutput("reset.chkLoad", int'(chkLoad), 0);
    checkOutput("reset.locked", int'(locked), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.timeout", int'(timeout), 0);
    checkOutput("reset.errCnt", int'(errCnt16), 0);

    $display("[TB] start and abort together in IDLE");
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("startAbort.busy", int'(busy), 0);
    checkOutput("startAbort.genLoad", int'(genLoad), 0);

    $display("[TB] clean run with an ignored start");
    clearSeq();
    applyStimulus("clean", 100, -1, 50);

    $display("[TB] sparse errors");
    clearSeq();
    for (int i = 0; i < 5; i++) errSeq[80 + 150 * i] = 1'b1;
    applyStimulus("sparse", 1000, -1, -1);

    $display("[TB] loss of lock");
    clearSeq();
    for (int i = 0; i < 8; i++) errSeq[75 + i] = 1'b1;
    applyStimulus("los", 200, -1, -1);

    $display("[TB] acquisition timeout");
    clearSeq();
    for (int i = 33; i < SEQ_LEN; i++) errSeq[i] = i[0];
    applyStimulus("timeout", 100, -1, -1);

    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("resetClears.timeout", int'(timeout), 0);

    $display("[TB] zero-length window");
    clearSeq();
    applyStimulus("win0", 0, -1, -1);

    $display("[TB] saturation");
    clearSeq();
    for (int i = 0; i < 20; i++) errSeq[65 + 5 * i] = 1'b1;
    applyStimulus("sat", 120, -1, -1);

    $display("[TB] abort mid-check");
    clearSeq();
    errSeq[70] = 1'b1;
    errSeq[80] = 1'b1;
    applyStimulus("abort", 100, 100, -1);

    $display("[TB] reset mid-run");
    clearSeq();
    errSeq[70] = 1'b1;
    errSeq[71] = 1'b1;
    @(posedge clk); #1;
    win_len = WIN_W'(200);
    start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      err_in = errAt(c);
    end
    @(negedge clk);
    checkOutput("midrun.errCnt", int'(errCnt16), 2);
    checkOutput("midrun.locked", int'(locked), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    err_in = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrun.resetBusy", int'(busy), 0);
    checkOutput("midrun.resetLocked", int'(locked), 0);
    checkOutput("midrun.resetErrCnt", int'(errCnt16), 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      int p;
      int wl;
      p  = pTab[r % 4];
      wl = $urandom_range(300, 0);
      for (int i = 0; i < SEQ_LEN; i++) errSeq[i] = ($urandom_range(99, 0) < p);
      applyStimulus($sformatf("rand%0d", r), wl, -1, -1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/prbs31_test_ctrl.md
# prbs31_test_ctrl

Sequencing controller for the PRBS31 generator/checker pair. It loads seeds, steps the generator, self-synchronises the checker, declares lock, and counts bit errors over a programmable window. Loss of lock triggers re-acquisition. A one-cycle `done` is raised when the window completes. It sits between the top-level pin logic and the PRBS31 shift registers, and owns every enable and load strobe they receive.

## Interface
Parameters:
- `WIN_W`, 16: width of the window-length input and the window counter.
- `ERR_W`, 16: width of the error counter, which saturates.
- `LOCK_CNT`, 32: consecutive error-free bits required to declare lock.
- `LOS_THRESH`, 8: errors within one 32-bit block that cause loss of lock.
- `ACQ_TIMEOUT`, 1024: maximum number of bits spent in ACQ before the run aborts with a timeout.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, synchronous and active-high (asserted at 1). The name follows the top-level port convention.
- `start` in 1: pulse that begins a run. Accepted only in IDLE.
- `abort` in 1: returns the block to IDLE from any state.
- `win_len` in `WIN_W`: number of checked bits. Sampled when `start` is accepted.
- `err_in` in 1: checker mismatch for the current bit. Valid in any cycle where `gen_en` is 1.
- `gen_load` out 1: load the generator seed (31'd1).
- `chk_load` out 1: the checker shifts received bits into its state (self-sync).
- `gen_en` out 1: advance the generator and checker by one bit.
- `busy` out 1: high in every state except IDLE.
- `locked` out 1: high in CHECK only.
- `done` out 1: one-cycle pulse when the window completes.
- `timeout` out 1: sticky. Set when ACQ times out; cleared on the next accepted `start`.
- `err_cnt` out `ERR_W`: accumulated errors. Held after DONE; cleared on the next accepted `start`.
- `err_sat` out 1: high when `err_cnt` equals its all-ones value.

## Operation
States are IDLE, SEED, SYNC, ACQ, CHECK and DONE.
- **Reset**: state is IDLE. All outputs are 0, `err_cnt` is 0, and all internal counters are 0.
- **IDLE**: `start`=1 and `abort`=0 → SEED. This clears `err_cnt` and `timeout` and latches `win_len`.
- **SEED**: lasts 1 cycle. `gen_load`=1 and `chk_load`=1 → SYNC.
- **SYNC**: `gen_en`=1 and `chk_load`=1 for exactly 31 cycles. `err_in` is ignored. → ACQ.
- **ACQ**: `gen_en`=1.
  - The run counter increments on each clean bit and clears to 0 on each error.
  - When the run counter reaches `LOCK_CNT` → CHECK.
  - When the ACQ bit counter reaches `ACQ_TIMEOUT` → DONE with `timeout`=1 and no `done` pulse.
- **CHECK**: `gen_en`=1 and `locked`=1.
  - Each bit increments the window counter.
  - Each bit with `err_in`=1 increments `err_cnt`, saturating at the maximum value, and increments the block error counter.
  - The block error counter resets every 32 checked bits.
  - When the block error counter reaches `LOS_THRESH` → SYNC with `locked`=0. The window counter is held (not cleared) and `err_cnt` is kept.
  - When the window counter equals the latched `win_len` → DONE.
- **DONE**: lasts 1 cycle. `done`=1 unless the entry was a timeout. → IDLE.
- **Boundary conditions**:
  - `abort` in any state → IDLE on the next edge. There is no `done` pulse, and `err_cnt` holds its last value.
  - `start` together with `abort` in IDLE: `abort` wins.
  - `start` while `busy`=1 is ignored.
  - `win_len`=0: CHECK is entered and DONE is entered on the next cycle. No bits are counted and `err_cnt` stays 0.
  - The error on the bit that completes the window is counted.
  - The error on the bit that triggers loss of lock is counted.
  - Loss of lock and window completion in the same cycle: DONE wins.

## Timing
- All outputs are registered.
- The first cycle with `gen_en`=1 is one cycle after SEED.
- From an accepted `start` to CHECK with zero errors takes 1 + 1 + 31 + `LOCK_CNT` cycles.
- `done` is asserted `win_len` cycles after CHECK is entered, in the absence of loss of lock.
- `err_in` is sampled on the same edge as the `gen_en` cycle it belongs to.
- `rst_n` mid-run behaves like `abort`, and additionally clears `err_cnt` and `timeout`.

## Configuration
- **`PRBS_CTRL_ERR_INJECT_EN` defined**:
  - Adds input `inject` and output `gen_flip`.
  - An `inject` pulse in CHECK asserts `gen_flip` for the next `gen_en` cycle, which inverts exactly one generated bit.
  - Further `inject` pulses while the flip is pending are ignored.
- **Undefined**: neither port exists and the generated data is never altered.

## Structure
- **Package `prbs_ctrl_pkg`**: state enum, `PRBS_LEN`=31, `SEED_VAL`=31'd1, `BLOCK_LEN`=32, and default parameter constants.
- **Sub-module `prbs_err_counter`**:
  - Holds the saturating `err_cnt` and the block error counter.
  - Exposes `los` and `err_sat`.
  - Inputs are `clr`, `en` and `err_in`.
- The FSM and the window, run and timeout counters remain in the top module.

## Test plan
- **Clean run**: `win_len`=100, `err_in`=0 always. Requires `done` at cycle 33+32+100 after `start`, `err_cnt`=0, `timeout`=0, and `locked` high for exactly 100 cycles.
- **Sparse errors**: `win_len`=1000 with 5 isolated errors in CHECK. Requires `err_cnt`=5 at `done` and `locked` never drops.
- **Loss of lock**: 8 errors within one 32-bit block in CHECK. Requires `locked`→0, re-entry to SYNC, and `done` only after the remaining window bits complete following relock.
- **Acquisition timeout**: `err_in` toggling every bit in ACQ. Requires `timeout`=1 after 1024 ACQ bits, no `done`, and return to IDLE.
- **Abort and saturation**: `abort` mid-CHECK → IDLE next cycle with no `done`. Separately, `ERR_W`=4 with 20 errors requires `err_cnt`=15 and `err_sat`=1.
- **Error injection** (with `PRBS_CTRL_ERR_INJECT_EN`): one `inject` in CHECK with the checker in loopback. Requires exactly one `gen_flip` cycle and `err_cnt`=1.
